demux_1to5_buf: RTL and testbench
=================================

// Module: demux_1to5_buf
// PURPOSE
//   Registered 1-to-5 demultiplexer: the write-side counterpart of the 5-way datapath mux.
//   Routes one DATA_WIDTH word to one of five destination slots chosen by a 3-bit selector.
//   Each slot is a single-entry buffer with valid/ack handshake; a full slot back-pressures the source.
//   Used in the multicycle datapath to deliver one producer result to one of five consumers.
// PARAMETERS
//   DATA_WIDTH  32  width of data_in and each data_out_k
// PORTS
//   clk        in   1           system clock; all state updates on rising edge
//   reset      in   1           synchronous, active-high reset
//   in_valid   in   1           source presents a word this cycle
//   in_ready   out  1           block accepts the word this cycle (combinational)
//   selector   in   3           destination: 0..3 -> slot 0..3; 4..7 -> slot 4
//   data_in    in   DATA_WIDTH  word to route
//   out_valid  out  5           bit k set: slot k holds an unconsumed word
//   out_ack    in   5           bit k: consumer k takes slot k this cycle
//   data_out_0 out  DATA_WIDTH  slot 0 word (registered)
//   data_out_1 out  DATA_WIDTH  slot 1 word (registered)
//   data_out_2 out  DATA_WIDTH  slot 2 word (registered)
//   data_out_3 out  DATA_WIDTH  slot 3 word (registered)
//   data_out_4 out  DATA_WIDTH  slot 4 word (registered)
// BEHAVIOUR
//   - Reset is synchronous, active-high, one clock; no asynchronous reset path.
//   - Reset values: out_valid=5'b0, data_out_0..4 = 0. While reset=1, in_ready=0 and all acks are ignored.
//   - dest = (selector >= 3'd4) ? 4 : selector[1:0]. Selector codes 5..7 alias to slot 4.
//   - in_ready = !reset && (!out_valid[dest] || out_ack[dest]).
//     in_ready is combinational from selector, out_valid and out_ack; it never depends on in_valid.
//   - Accept: in_valid && in_ready at an edge. At that edge, data_out_dest <= data_in and out_valid[dest] <= 1.
//     Latency is 1 cycle from accept to visible data and valid.
//   - Consume: out_valid[k] && out_ack[k] at an edge clears out_valid[k], unless a same-edge accept targets k.
//     In that case the new word is loaded and out_valid[k] stays 1 (back-to-back, no bubble).
//   - out_ack[k] while out_valid[k]=0 is ignored; it creates no state change and no error.
//   - Acks to different slots and an accept to another slot in the same cycle are all independent; each takes effect.
//   - data_out_k changes only on accept into slot k. After consume it holds the last value.
//   - Non-accepted slots are never written. At most one slot is written per cycle.
//   - The source must hold in_valid, selector and data_in stable until accepted.
//     Any change before acceptance is a protocol violation and is not checked.
//   - Reset asserted with slots full drops all buffered words: out_valid=0 at the next edge and data is zeroed.
//     A transfer pending in that cycle is not accepted.
//   - No internal counters or wrap-around; storage is five registers of DATA_WIDTH plus 5 valid flags.
// TESTING
//   1. Reset with all inputs X-free -> out_valid=0, data_out_0..4=0, in_ready=0 during reset, 1 after.
//   2. Write sel=2, data=32'hDEADBEEF -> next cycle out_valid=5'b00100, data_out_2=DEADBEEF; other slots unchanged.
//   3. Slot 1 full, no ack, sel=1, data=32'h1234 -> in_ready=0, data_out_1 unchanged.
//      Then ack[1]=1 same cycle -> accepted; out_valid[1] stays 1 and data_out_1=1234.
//   4. sel=5, data=32'hA5A5A5A5 -> slot 4 loaded, out_valid=5'b10000. Repeat with sel=7 while full, no ack -> in_ready=0.
//   5. Fill slots 0..4 with 1..5, then ack=5'b11111 with sel=0, data=32'h99 -> out_valid=5'b00001, data_out_0=99.
//      Slots 1..4 hold 2..5 with their valid bits clear.
//   6. Slots 0 and 3 full; assert reset with in_valid=1, sel=3 -> next cycle out_valid=0 and all data_out=0; nothing accepted.

Source files
------------

// File: rtl/demux_1to5_buf.sv
// demux_1to5_buf: registered 1-to-5 demultiplexer into five single-entry slots.
// Each slot has a valid/ack handshake, and a full slot back-pressures the source.
`default_nettype none

module demux_1to5_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            selector,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [4:0]            out_valid,
  input  logic [4:0]            out_ack,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic [DATA_WIDTH-1:0] data_out_3,
  output logic [DATA_WIDTH-1:0] data_out_4
);

  logic [4:0]            dest_oh;
  logic [4:0]            load;
  logic [4:0]            valid_q;
  logic [4:0]            valid_d;
  logic [DATA_WIDTH-1:0] data_q [5];

  // Codes 4..7 all alias to slot 4.
  always_comb begin
    dest_oh = 5'b00001 << selector[1:0];
    if (selector[2]) begin
      dest_oh = 5'b10000;
    end
  end

  assign in_ready = !reset && (|(dest_oh & (~valid_q | out_ack)));
  assign load     = dest_oh & {5{in_valid && in_ready}};
  assign valid_d  = (valid_q & ~out_ack) | load;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 5'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < 5; k++) begin : g_slot
    always_ff @(posedge clk) begin
      if (reset) begin
        data_q[k] <= '0;
      end else if (load[k]) begin
        data_q[k] <= data_in;
      end
    end
  end

  assign out_valid  = valid_q;
  assign data_out_0 = data_q[0];
  assign data_out_1 = data_q[1];
  assign data_out_2 = data_q[2];
  assign data_out_3 = data_q[3];
  assign data_out_4 = data_q[4];

endmodule

`default_nettype wire

// File: tb/tb_demux_1to5_buf.sv
// Bench for demux_1to5_buf: directed writes, with a scoreboard that checks every consumed word.
`default_nettype none

module tb_demux_1to5_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  selector;
  logic [31:0] data_in;
  logic [4:0]  out_valid;
  logic [4:0]  out_ack;
  logic [31:0] data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
  logic [31:0] dout [5];

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q [5][$];

  demux_1to5_buf #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .selector(selector), .data_in(data_in), .out_valid(out_valid), .out_ack(out_ack),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .data_out_3(data_out_3), .data_out_4(data_out_4)
  );

  always #5 clk = ~clk;

  assign dout[0] = data_out_0;
  assign dout[1] = data_out_1;
  assign dout[2] = data_out_2;
  assign dout[3] = data_out_3;
  assign dout[4] = data_out_4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a consume happens at the next rising edge, so the word must match the queue head now.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 5; k++) begin
        if (out_valid[k] && out_ack[k]) begin
          if (exp_q[k].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL consume_slot%0d: got %h expected no word", k, dout[k]);
          end else begin
            chk($sformatf("consume_slot%0d", k), dout[k], exp_q[k].pop_front());
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one write, check in_ready against the expectation, and queue the word if it goes in.
  task automatic drive(input logic [2:0] sel, input logic [31:0] d, input logic [4:0] ack,
                       input int slot, input logic exp_rdy);
    in_valid = 1'b1;
    selector = sel;
    data_in  = d;
    out_ack  = ack;
    #1;
    chk($sformatf("in_ready_sel%0d", sel), {31'b0, in_ready}, {31'b0, exp_rdy});
    if (exp_rdy) exp_q[slot].push_back(d);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_ack  = 5'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; selector = 3'd0; data_in = 32'h0; out_ack = 5'b0;
    cyc();
    cyc();
    // 1. reset state
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {27'b0, out_valid}, 32'd0);
    for (int k = 0; k < 5; k++) chk($sformatf("rst_data%0d", k), dout[k], 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // 2. single write to slot 2
    drive(3'd2, 32'hDEADBEEF, 5'b0, 2, 1'b1);
    cyc(); idle();
    chk("w2_out_valid", {27'b0, out_valid}, 32'h04);
    chk("w2_data2", data_out_2, 32'hDEADBEEF);
    chk("w2_data0", data_out_0, 32'h0);

    // 3. back-pressure on a full slot, then back-to-back accept with ack
    drive(3'd1, 32'h1111, 5'b0, 1, 1'b1);
    cyc(); idle();
    drive(3'd1, 32'h1234, 5'b0, 1, 1'b0);
    cyc();
    chk("bp_data1", data_out_1, 32'h1111);
    chk("bp_out_valid", {27'b0, out_valid}, 32'h06);
    drive(3'd1, 32'h1234, 5'b00010, 1, 1'b1);
    cyc(); idle();
    chk("b2b_out_valid", {27'b0, out_valid}, 32'h06);
    chk("b2b_data1", data_out_1, 32'h1234);
    out_ack = 5'b00110;
    cyc(); idle();
    chk("drain12_out_valid", {27'b0, out_valid}, 32'h00);

    // 4. aliased selectors reach slot 4
    drive(3'd5, 32'hA5A5A5A5, 5'b0, 4, 1'b1);
    cyc(); idle();
    chk("sel5_out_valid", {27'b0, out_valid}, 32'h10);
    chk("sel5_data4", data_out_4, 32'hA5A5A5A5);
    drive(3'd7, 32'h77, 5'b0, 4, 1'b0);
    cyc(); idle();
    chk("sel7_bp_data4", data_out_4, 32'hA5A5A5A5);
    out_ack = 5'b10000;
    cyc(); idle();

    // 5. fill all slots, then ack everything while refilling slot 0
    for (int k = 0; k < 5; k++) begin
      drive(3'(k), 32'(k + 1), 5'b0, k, 1'b1);
      cyc();
    end
    idle();
    #1;
    chk("full_out_valid", {27'b0, out_valid}, 32'h1F);
    drive(3'd0, 32'h99, 5'b11111, 0, 1'b1);
    cyc(); idle();
    chk("ackall_out_valid", {27'b0, out_valid}, 32'h01);
    chk("ackall_data0", data_out_0, 32'h99);
    for (int k = 1; k < 5; k++) chk($sformatf("ackall_hold%0d", k), dout[k], 32'(k + 1));
    out_ack = 5'b00001;
    cyc(); idle();

    // 6. reset drops buffered words and blocks a pending transfer
    drive(3'd0, 32'hA0, 5'b0, 0, 1'b1);
    cyc();
    drive(3'd3, 32'hA3, 5'b0, 3, 1'b1);
    cyc(); idle();
    chk("pre_rst_out_valid", {27'b0, out_valid}, 32'h09);
    reset = 1'b1;
    drive(3'd3, 32'hFF, 5'b0, 3, 1'b0);
    for (int k = 0; k < 5; k++) exp_q[k].delete();
    cyc();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_drop_out_valid", {27'b0, out_valid}, 32'h00);
    chk("rst_drop_data0", data_out_0, 32'h0);
    chk("rst_drop_data3", data_out_3, 32'h0);

    for (int k = 0; k < 5; k++) chk($sformatf("queue%0d_left", k), 32'(exp_q[k].size()), 32'd0);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
